// File: rtl/coeff_inverse_scan_8x8.sv
// Inverse scan for 8x8 coefficient blocks: scan-order beats are written to their raster
// slot in a 64-entry buffer, then the block is drained row-major on a second stream.
`timescale 1ns/1ps

module coeff_inverse_scan_8x8 #(
  parameter int COEFF_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         scan_type,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEFF_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] out_data,
  output logic [5:0]         out_idx,
  output logic               out_last,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_e;

  state_e       state_q, state_d;
  logic [5:0]   wr_q, wr_d;
  logic [5:0]   rd_q, rd_d;
  logic [2:0]   row_q, row_d;
  logic [2:0]   col_q, col_d;
  logic         up_q, up_d;
  logic [1:0]   scan_q, scan_d;

  logic [COEFF_W-1:0] mem_q [64];

  logic         in_fire;
  logic         out_fire;
  logic [1:0]   scan_eff;
  logic [5:0]   wr_addr;
  logic [2:0]   row_nx;
  logic [2:0]   col_nx;
  logic         up_nx;

  assign in_ready  = (state_q != S_DRAIN);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign out_idx   = rd_q;
  assign out_last  = out_valid && (rd_q == 6'd63);

  // Beat 0 uses the live scan_type; later beats use the value latched on beat 0.
  always_comb begin
    scan_eff = (state_q == S_IDLE) ? scan_type : scan_q;
    case (scan_eff)
      2'd1:    wr_addr = wr_q;
      2'd2:    wr_addr = {wr_q[2:0], wr_q[5:3]};
      default: wr_addr = {row_q, col_q};
    endcase
  end

  always_comb begin
    row_nx = row_q;
    col_nx = col_q;
    up_nx  = up_q;
    if (up_q) begin
      if (col_q == 3'd7) begin
        row_nx = row_q + 3'd1;
        up_nx  = 1'b0;
      end else if (row_q == 3'd0) begin
        col_nx = col_q + 3'd1;
        up_nx  = 1'b0;
      end else begin
        row_nx = row_q - 3'd1;
        col_nx = col_q + 3'd1;
      end
    end else begin
      if (row_q == 3'd7) begin
        col_nx = col_q + 3'd1;
        up_nx  = 1'b1;
      end else if (col_q == 3'd0) begin
        row_nx = row_q + 3'd1;
        up_nx  = 1'b1;
      end else begin
        row_nx = row_q + 3'd1;
        col_nx = col_q - 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    row_d   = row_q;
    col_d   = col_q;
    up_d    = up_q;
    scan_d  = scan_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          scan_d  = scan_type;
          wr_d    = wr_q + 6'd1;
          row_d   = row_nx;
          col_d   = col_nx;
          up_d    = up_nx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_fire) begin
          wr_d  = wr_q + 6'd1;
          row_d = row_nx;
          col_d = col_nx;
          up_d  = up_nx;
          if (wr_q == 6'd63) begin
            // Walker is rewound here so it is already home when IDLE is re-entered.
            state_d = S_DRAIN;
            wr_d    = '0;
            row_d   = '0;
            col_d   = '0;
            up_d    = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          rd_d = rd_q + 6'd1;
          if (rd_q == 6'd63) begin
            rd_d    = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      up_q    <= 1'b1;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      row_q   <= row_d;
      col_q   <= col_d;
      up_q    <= up_d;
      scan_q  <= scan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem_q[wr_addr] <= in_data;
  end

endmodule

// File: tb/tb_coeff_inverse_scan_8x8.sv
// Directed bench for coeff_inverse_scan_8x8: loads blocks in each scan order and checks
// the raster-order drain against a hand-written zig-zag table and transpose rule.
`timescale 1ns/1ps

module tb_coeff_inverse_scan_8x8;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   scan_type;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [5:0]   out_idx;
  logic         out_last;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  // zig-zag: scan index k found at each raster position (row-major)
  int zz_tbl [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  coeff_inverse_scan_8x8 #(.COEFF_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_type (scan_type),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 zig-zag, 1 horizontal, 2 vertical
  function automatic int exp_k(input int kind, input int idx);
    case (kind)
      1:       return idx;
      2:       return (idx % 8) * 8 + idx / 8;
      default: return zz_tbl[idx];
    endcase
  endfunction

  task automatic send_block(input logic [1:0] st0, input bit toggle, input logic [15:0] base,
                            input bit gaps, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          tick();
          check("load_gap_ov", 32'(out_valid), 0);
        end
      end
      in_valid  = 1'b1;
      in_data   = 16'(base + 16'(k));
      scan_type = (k == 0 || !toggle) ? st0 : 2'($urandom_range(0, 3));
      check("load_rdy", 32'(in_ready), 1);
      tick();
      check("load_ov", 32'(out_valid), (k == 63) ? 1 : 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_block(input int kind, input logic [15:0] base, input int stall_at,
                            input bit poke);
    logic [15:0] e;
    for (int i = 0; i < 64; i++) begin
      int n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      if (n == 20) check("ov_timeout", 0, 1);
      e = 16'(base + 16'(exp_k(kind, i)));
      check("idx", 32'(out_idx), i);
      check("data", 32'(out_data), 32'(e));
      check("last", 32'(out_last), (i == 63) ? 1 : 0);
      check("drain_rdy", 32'(in_ready), 0);
      check("drain_busy", 32'(busy), 1);
      in_valid = poke && (i < 63);
      in_data  = 16'hDEAD;
      if (i == stall_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          tick();
          check("stall_ov", 32'(out_valid), 1);
          check("stall_idx", 32'(out_idx), i);
          check("stall_data", 32'(out_data), 32'(e));
          check("stall_rdy", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    check("end_ov", 32'(out_valid), 0);
    check("end_rdy", 32'(in_ready), 1);
    check("end_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    scan_type = 2'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", 32'(out_valid), 0);
    check("rst_rdy", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_idx", 32'(out_idx), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_data", 32'(out_data), 0);
    rst = 1'b0;
    tick();

    // horizontal, vertical, zig-zag with data = k
    send_block(2'd1, 1'b0, 16'd0, 1'b0, 64);
    recv_block(1, 16'd0, -1, 1'b0);
    send_block(2'd2, 1'b0, 16'd0, 1'b0, 64);
    recv_block(2, 16'd0, -1, 1'b0);
    send_block(2'd0, 1'b0, 16'd0, 1'b0, 64);
    recv_block(0, 16'd0, -1, 1'b0);

    // input gaps, output stall at idx 10, in_valid held high during drain
    send_block(2'd0, 1'b0, 16'h8000, 1'b1, 64);
    recv_block(0, 16'h8000, 10, 1'b1);

    // scan_type churn after beat 0; 3 behaves as zig-zag
    send_block(2'd3, 1'b1, 16'd100, 1'b0, 64);
    recv_block(0, 16'd100, -1, 1'b0);
    send_block(2'd1, 1'b1, 16'd200, 1'b0, 64);
    recv_block(1, 16'd200, -1, 1'b0);

    // reset after 30 beats, then a clean horizontal block
    send_block(2'd2, 1'b0, 16'd500, 1'b0, 30);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #2;
    check("arst_ov", 32'(out_valid), 0);
    check("arst_rdy", 32'(in_ready), 1);
    check("arst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_ov", 32'(out_valid), 0);
    check("post_rst_idx", 32'(out_idx), 0);
    send_block(2'd1, 1'b0, 16'd0, 1'b0, 64);
    recv_block(1, 16'd0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
